shift_add_mult_seq: RTL and testbench

Parametrised sequential shift-and-add multiplier with an integrated result register bank. It computes one WIDTH×WIDTH product over WIDTH iterations, in unsigned or two's-complement signed mode selected per operation. Each product is written into a DEPTH-entry bank at a caller-chosen address, and any entry can be read back through an independent port. It is the multi-cycle, handshaked successor to the team's combinational 16-bit multiplier-plus-RAM datapath, and sits on the arithmetic unit's register-file side.

---
 rtl/shift_add_mult_seq_pkg.sv | 17 +
 rtl/mult_result_bank.sv | 39 +++
 rtl/shift_add_mult_seq.sv | 140 ++++++++++++++
 tb/tb_shift_add_mult_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package shift_add_mult_seq_pkg;

    localparam int unsigned MAX_PROD_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement negation; callers widen into and truncate out of MAX_PROD_W.
    function automatic logic [MAX_PROD_W-1:0] twos_neg(input logic [MAX_PROD_W-1:0] v);
        return (~v) + MAX_PROD_W'(1);
    endfunction

endpackage

// File: rtl/mult_result_bank.sv
// DEPTH x DW result register bank: async reset, one synchronous write port, one combinational read port.
module mult_result_bank #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A same-cycle write is visible only from the following cycle.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier (unsigned or signed per operation)
// writing each product into a DEPTH-entry result bank.
module shift_add_mult_seq
    import shift_add_mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [AW-1:0]      waddr,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    input  logic [AW-1:0]      raddr,
    output logic [2*WIDTH-1:0] rdata
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH-1:0] a_abs_c, b_abs_c;
    logic [PW-1:0]    final_c;
    logic             bank_we_c;

    // Magnitudes fit in WIDTH bits unsigned, including -2^(WIDTH-1).
    assign a_abs_c = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_abs_c = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign final_c = neg_q ? PW'(twos_neg(MAX_PROD_W'(acc_q))) : acc_q;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        waddr_d   = waddr_q;
        product_d = product_q;
        done_d    = 1'b0;
        bank_we_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = PW'(a_abs_c);
                    mplier_d = b_abs_c;
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    waddr_d  = waddr;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d = final_c;
                done_d    = 1'b1;
                bank_we_c = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            waddr_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            waddr_q   <= waddr_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign product = product_q;

    mult_result_bank #(
        .DEPTH (DEPTH),
        .DW    (PW),
        .AW    (AW)
    ) u_bank (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (bank_we_c),
        .waddr (waddr_q),
        .wdata (final_c),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Self-checking bench for shift_add_mult_seq: scoreboard of expected products plus bank model.
module tb_shift_add_mult_seq;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned PW    = 32;

    logic          CLK;
    logic          RST_N;
    logic          start;
    logic          signed_mode;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [AW-1:0] waddr;
    logic          ready;
    logic          done;
    logic [PW-1:0] product;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rdata;

    int            n_tests;
    int            n_fail;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] model[DEPTH];
    logic [PW-1:0] mon_exp;

    shift_add_mult_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .waddr       (waddr),
        .ready       (ready),
        .done        (done),
        .product     (product),
        .raddr       (raddr),
        .rdata       (rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: every done pulse pops one expected product.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && done === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected product=%h", product);
            end else begin
                mon_exp = exp_q.pop_front();
                if (product !== mon_exp) begin
                    n_fail++;
                    $display("FAIL product got=%h exp=%h", product, mon_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] a_i, input logic [15:0] b_i,
                          input logic sm, input logic [AW-1:0] wa, input bit glitch);
        logic [PW-1:0] ae, be, expv, old;
        int lat;
        bit got, ctl_bad;
        ae   = sm ? {{16{a_i[15]}}, a_i} : {16'h0, a_i};
        be   = sm ? {{16{b_i[15]}}, b_i} : {16'h0, b_i};
        expv = ae * be;
        @(negedge CLK);
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_start got=%b exp=1", ready);
        end
        raddr = wa;
        old   = model[wa];
        start = 1'b1; a = a_i; b = b_i; signed_mode = sm; waddr = wa;
        exp_q.push_back(expv);
        @(posedge CLK);
        #1 start = 1'b0;
        lat = 0; got = 1'b0; ctl_bad = 1'b0;
        while (!got && lat < 40) begin
            @(posedge CLK);
            #1 lat++;
            if (glitch && lat == 5) begin
                start = 1'b1; a = ~a_i; b = b_i + 16'h1111;
                waddr = wa + 3'd1; signed_mode = ~sm;
            end
            if (glitch && lat == 6) start = 1'b0;
            if (lat == 16) begin
                n_tests++;
                if (rdata !== old) begin
                    n_fail++;
                    $display("FAIL rdata_in_done_cycle got=%h exp=%h", rdata, old);
                end
            end
            if (done === 1'b1) got = 1'b1;
            else if (ready !== 1'b0) ctl_bad = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout waited=%0d", lat);
            exp_q.delete();
        end else if (lat != 17) begin
            n_fail++;
            $display("FAIL latency got=%0d exp=17", lat);
        end
        n_tests++;
        if (ctl_bad) begin
            n_fail++;
            $display("FAIL ready_low_during_op got=1 exp=0");
        end
        if (got) begin
            model[wa] = expv;
            n_tests++;
            if (rdata !== expv) begin
                n_fail++;
                $display("FAIL rdata_after_write addr=%0d got=%h exp=%h", wa, rdata, expv);
            end
            n_tests++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_with_done got=%b exp=1", ready);
            end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs ready=%b done=%b product=%h exp 1/0/0", ready, done, product);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            raddr = AW'(i);
            #1;
            n_tests++;
            if (rdata !== '0) begin
                n_fail++;
                $display("FAIL reset_bank addr=%0d got=%h exp=0", i, rdata);
            end
        end
    endtask

    task automatic test_unsigned();
        run_op(16'd3, 16'd5, 1'b0, 3'd0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (product !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL product_hold got=%h exp=0000000f", product);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 3'd1, 1'b0);
        run_op(16'h0000, 16'h1234, 1'b0, 3'd2, 1'b0);
    endtask

    task automatic test_signed();
        run_op(16'hFFFD, 16'd5,    1'b1, 3'd3, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b1, 3'd4, 1'b0);
        run_op(16'h8000, 16'h7FFF, 1'b1, 3'd5, 1'b0);
    endtask

    task automatic test_handshake();
        run_op(16'h1234, 16'h0056, 1'b0, 3'd6, 1'b1);
        raddr = 3'd7;
        #1;
        n_tests++;
        if (rdata !== model[7]) begin
            n_fail++;
            $display("FAIL ignored_start_wrote addr=7 got=%h exp=%h", rdata, model[7]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < int'(DEPTH); i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(1)), AW'(i), 1'b0);
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge CLK);
            raddr = AW'(i);
            #1;
            n_tests++;
            if (rdata !== model[i]) begin
                n_fail++;
                $display("FAIL readback addr=%0d got=%h exp=%h", i, rdata, model[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        raddr = 3'd3;
        start = 1'b1; a = 16'd7; b = 16'd9; signed_mode = 1'b0; waddr = 3'd3;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || product !== '0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid ready=%b done=%b product=%h bank3=%h exp 1/0/0/0",
                     ready, done, product, rdata);
        end
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        run_op(16'd100, 16'd200, 1'b0, 3'd3, 1'b0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        RST_N = 1'b0; start = 1'b0; signed_mode = 1'b0;
        a = '0; b = '0; waddr = '0; raddr = '0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        test_unsigned();
        test_signed();
        test_handshake();
        test_back_to_back();
        test_readback();
        test_reset_mid();
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
